// File: rtl/dmem_req_sched_pkg.sv
// Shared types for the data-memory request scheduler: access size, muxed request record
// and the width of the pipe id carried through the in-flight order FIFO.
package dmem_req_sched_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  localparam int DMEM_PIPE_ID_W = 1;

  typedef struct packed {
    logic        wr;
    mem_size_t   size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } dmem_req_t;

endpackage

// File: rtl/dmem_req_sched_id_fifo.sv
// Order FIFO of pipe ids for requests in flight; supports push and pop in the same cycle
// plus a synchronous clear used when the pipeline flushes.
module dmem_id_fifo
  import dmem_req_sched_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = DMEM_PIPE_ID_W
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       clear,
  input  logic                       push,
  input  logic [W-1:0]               push_id,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/dmem_req_sched.sv
// Issues pipe 0/1 memory requests in program order to the single MMU data port and routes
// in-order responses back; define DMEM_SCHED_PERF_EN to add request/stall perf counters.
module dmem_req_sched
  import dmem_req_sched_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        req0_valid,
  input  logic        req0_wr,
  input  mem_size_t   req0_size,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [3:0]  req0_wstrb,
  output logic        req0_accept,
  input  logic        req1_valid,
  input  logic        req1_wr,
  input  mem_size_t   req1_size,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [3:0]  req1_wstrb,
  output logic        req1_accept,
  output logic        mmu_req,
  output logic        mmu_wr,
  output mem_size_t   mmu_size,
  output logic [31:0] mmu_addr,
  output logic [31:0] mmu_wdata,
  output logic [3:0]  mmu_wstrb,
  input  logic        mmu_addr_ok,
  input  logic        mmu_data_ok,
  input  logic [31:0] mmu_rdata,
  output logic        rsp0_data_ok,
  output logic        rsp1_data_ok,
  output logic [31:0] rsp_rdata,
`ifdef DMEM_SCHED_PERF_EN
  output logic [31:0] perf_req_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  output logic        busy
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  dmem_req_t                 req0, req1, sel_req;
  logic                      sel_valid;
  logic [DMEM_PIPE_ID_W-1:0] sel_id;
  logic [DMEM_PIPE_ID_W-1:0] head_id;
  logic [CW-1:0]             discard_cnt;
  logic [CW-1:0]             fifo_count;
  logic [CW-1:0]             n_inflight;
  logic                      accept;
  logic                      rsp_any;
  logic                      pop_head;

  assign req0 = '{wr: req0_wr, size: req0_size, addr: req0_addr, wdata: req0_wdata, wstrb: req0_wstrb};
  assign req1 = '{wr: req1_wr, size: req1_size, addr: req1_addr, wdata: req1_wdata, wstrb: req1_wstrb};

  // Pipe 0 is always older, so pipe 1 only goes once pipe 0 has nothing pending.
  assign sel_valid = req0_valid || req1_valid;
  assign sel_id    = req0_valid ? 1'b0 : 1'b1;
  assign sel_req   = req0_valid ? req0 : req1;

  assign mmu_wr    = sel_req.wr;
  assign mmu_size  = sel_req.size;
  assign mmu_addr  = sel_req.addr;
  assign mmu_wdata = sel_req.wdata;
  assign mmu_wstrb = sel_req.wstrb;

  assign n_inflight  = discard_cnt + fifo_count;
  assign mmu_req     = resetn && !flush && sel_valid && (n_inflight < CW'(MAX_OUTSTANDING));
  assign accept      = mmu_req && mmu_addr_ok;
  assign req0_accept = accept && (sel_id == 1'b0);
  assign req1_accept = accept && (sel_id == 1'b1);

  // Discarded responses come back first because the MMU answers strictly in order.
  assign rsp_any      = resetn && mmu_data_ok && (n_inflight != '0);
  assign pop_head     = rsp_any && !flush && (discard_cnt == '0);
  assign rsp0_data_ok = pop_head && (head_id == 1'b0);
  assign rsp1_data_ok = pop_head && (head_id == 1'b1);
  assign rsp_rdata    = mmu_rdata;
  assign busy         = resetn && (n_inflight != '0);

  always_ff @(posedge clk) begin
    if (!resetn)
      discard_cnt <= '0;
    else if (flush)
      discard_cnt <= n_inflight - CW'(rsp_any);
    else if (rsp_any && (discard_cnt != '0))
      discard_cnt <= discard_cnt - CW'(1);
  end

  dmem_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (DMEM_PIPE_ID_W)
  ) u_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (flush),
    .push    (accept),
    .push_id (sel_id),
    .pop     (pop_head),
    .head    (head_id),
    .count   (fifo_count)
  );

`ifdef DMEM_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_req_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (accept) perf_req_cnt <= perf_req_cnt + 32'd1;
      if (sel_valid && !flush && !accept) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

  // A response with nothing outstanding means the MMU broke the handshake.
  assert property (@(posedge clk) disable iff (!resetn) !(mmu_data_ok && (n_inflight == '0)));

endmodule

// File: tb/tb_dmem_req_sched.sv
// Bench for dmem_req_sched: hand-derived vector table, perf sequence, then random traffic
// checked against a queue-of-owners reference model.
module tb_dmem_req_sched;
  import dmem_req_sched_pkg::*;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        resetn, flush;
  logic        req0_valid, req0_wr, req0_accept;
  mem_size_t   req0_size;
  logic [31:0] req0_addr, req0_wdata;
  logic [3:0]  req0_wstrb;
  logic        req1_valid, req1_wr, req1_accept;
  mem_size_t   req1_size;
  logic [31:0] req1_addr, req1_wdata;
  logic [3:0]  req1_wstrb;
  logic        mmu_req, mmu_wr;
  mem_size_t   mmu_size;
  logic [31:0] mmu_addr, mmu_wdata;
  logic [3:0]  mmu_wstrb;
  logic        mmu_addr_ok, mmu_data_ok;
  logic [31:0] mmu_rdata, rsp_rdata;
  logic        rsp0_data_ok, rsp1_data_ok, busy;
`ifdef DMEM_SCHED_PERF_EN
  logic [31:0] perf_req_cnt, perf_stall_cnt;
  logic [31:0] m_req_cnt, m_stall_cnt;
`endif

  always #5 clk = ~clk;

  dmem_req_sched #(.MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_size(req0_size), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb), .req0_accept(req0_accept),
    .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_size(req1_size), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb), .req1_accept(req1_accept),
    .mmu_req(mmu_req), .mmu_wr(mmu_wr), .mmu_size(mmu_size), .mmu_addr(mmu_addr),
    .mmu_wdata(mmu_wdata), .mmu_wstrb(mmu_wstrb), .mmu_addr_ok(mmu_addr_ok),
    .mmu_data_ok(mmu_data_ok), .mmu_rdata(mmu_rdata),
    .rsp0_data_ok(rsp0_data_ok), .rsp1_data_ok(rsp1_data_ok), .rsp_rdata(rsp_rdata),
`ifdef DMEM_SCHED_PERF_EN
    .perf_req_cnt(perf_req_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
    .busy(busy)
  );

  typedef struct {
    bit         rn, fl, v0, v1, aok, dok;
    logic [5:0] exp;
  } vec_t;

  int        vec_cnt = 0;
  int        err_cnt = 0;
  bit        pv [2];
  dmem_req_t pr [2];
  int        inflight [$];
  vec_t      tab [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, compare at the falling edge, then advance the reference model.
  task automatic applyStimulus(input bit rn, fl, aok, dok, input bit use_tab,
                               input logic [5:0] tab_exp, input string tag);
    int         n, sel;
    bit         exp_req, acc, r0, r1, busy_e;
    logic [5:0] exp_flags;
    resetn = rn; flush = fl; mmu_addr_ok = aok; mmu_data_ok = dok;
    mmu_rdata  = $urandom;
    req0_valid = pv[0]; req0_wr = pr[0].wr; req0_size = pr[0].size; req0_addr = pr[0].addr;
    req0_wdata = pr[0].wdata; req0_wstrb = pr[0].wstrb;
    req1_valid = pv[1]; req1_wr = pr[1].wr; req1_size = pr[1].size; req1_addr = pr[1].addr;
    req1_wdata = pr[1].wdata; req1_wstrb = pr[1].wstrb;
    @(negedge clk);
    n       = inflight.size();
    sel     = pv[0] ? 0 : 1;
    exp_req = rn && !fl && (pv[0] || pv[1]) && (n < MAX);
    acc     = exp_req && aok;
    r0 = 1'b0; r1 = 1'b0;
    if (rn && dok && n > 0 && !fl) begin
      if (inflight[0] == 0) r0 = 1'b1;
      else if (inflight[0] == 1) r1 = 1'b1;
    end
    busy_e    = rn && (n > 0);
    exp_flags = use_tab ? tab_exp : {exp_req, acc && sel == 0, acc && sel == 1, r0, r1, busy_e};
    checkOutput({tag, " flags{req,acc0,acc1,rsp0,rsp1,busy}"},
                {26'd0, mmu_req, req0_accept, req1_accept, rsp0_data_ok, rsp1_data_ok, busy},
                {26'd0, exp_flags});
    checkOutput({tag, " rsp_rdata"}, rsp_rdata, mmu_rdata);
    if (exp_req) begin
      checkOutput({tag, " mmu_addr"}, mmu_addr, pr[sel].addr);
      checkOutput({tag, " mmu_wdata"}, mmu_wdata, pr[sel].wdata);
      checkOutput({tag, " mmu_wr/size/wstrb"}, {25'd0, mmu_wr, mmu_size, mmu_wstrb},
                  {25'd0, pr[sel].wr, pr[sel].size, pr[sel].wstrb});
    end
`ifdef DMEM_SCHED_PERF_EN
    checkOutput({tag, " perf_req_cnt"}, perf_req_cnt, m_req_cnt);
    checkOutput({tag, " perf_stall_cnt"}, perf_stall_cnt, m_stall_cnt);
    if (!rn) begin
      m_req_cnt = 0; m_stall_cnt = 0;
    end else begin
      if (acc) m_req_cnt++;
      if ((pv[0] || pv[1]) && !fl && !acc) m_stall_cnt++;
    end
`endif
    if (!rn) inflight.delete();
    else begin
      if (dok && n > 0) void'(inflight.pop_front());
      if (fl) foreach (inflight[i]) inflight[i] = -1;
      if (acc) inflight.push_back(sel);
    end
    if (acc) pv[sel] = 1'b0;
    if (fl || !rn) begin
      pv[0] = 1'b0; pv[1] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; mmu_addr_ok = 1'b0; mmu_data_ok = 1'b0; mmu_rdata = '0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    pv[0] = 1'b0; pv[1] = 1'b0;
    pr[0] = '{wr: 1'b0, size: MEM_WORD, addr: 32'h0000_1000, wdata: 32'h1111_0000, wstrb: 4'hF};
    pr[1] = '{wr: 1'b1, size: MEM_HALF, addr: 32'h0000_2000, wdata: 32'h2222_0000, wstrb: 4'h3};
`ifdef DMEM_SCHED_PERF_EN
    m_req_cnt = 0; m_stall_cnt = 0;
`endif
    // rn fl v0 v1 aok dok | {req,acc0,acc1,rsp0,rsp1,busy}
    tab.push_back('{0,0,1,0,1,0,6'b000000});
    tab.push_back('{1,0,1,0,0,0,6'b100000});
    tab.push_back('{1,0,1,0,1,0,6'b110000});
    tab.push_back('{1,0,0,0,0,0,6'b000001});
    tab.push_back('{1,0,0,0,0,1,6'b000101});
    tab.push_back('{1,0,0,0,0,0,6'b000000});
    tab.push_back('{1,0,1,1,1,0,6'b110000});
    tab.push_back('{1,0,0,1,1,0,6'b101001});
    tab.push_back('{1,0,0,0,1,1,6'b000101});
    tab.push_back('{1,0,0,0,1,1,6'b000011});
    tab.push_back('{1,0,0,0,0,0,6'b000000});
    tab.push_back('{1,0,1,0,1,0,6'b110000});
    tab.push_back('{1,0,1,0,1,0,6'b110001});
    tab.push_back('{1,0,1,0,1,0,6'b000001});
    tab.push_back('{1,0,1,0,1,1,6'b000101});
    tab.push_back('{1,0,1,0,1,0,6'b110001});
    tab.push_back('{1,1,0,0,0,1,6'b000001});
    tab.push_back('{1,0,1,0,1,0,6'b110001});
    tab.push_back('{1,0,0,0,0,1,6'b000001});
    tab.push_back('{1,0,0,0,0,1,6'b000101});
    tab.push_back('{1,0,0,0,0,0,6'b000000});
    tab.push_back('{1,0,0,1,1,0,6'b101000});
    tab.push_back('{0,0,0,0,0,0,6'b000000});
    tab.push_back('{1,0,0,0,0,0,6'b000000});
    tab.push_back('{1,0,0,1,1,0,6'b101000});
    tab.push_back('{1,0,0,0,0,1,6'b000011});
    tab.push_back('{1,0,0,0,0,0,6'b000000});

    @(posedge clk);
    #1;
    for (int i = 0; i < tab.size(); i++) begin
      pv[0] = tab[i].v0; pv[1] = tab[i].v1;
      applyStimulus(tab[i].rn, tab[i].fl, tab[i].aok, tab[i].dok, 1'b1, tab[i].exp,
                    $sformatf("vec%0d", i));
    end

`ifdef DMEM_SCHED_PERF_EN
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, "perf_rst");
    for (int i = 0; i < 3; i++) begin
      pv[0] = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, "perf_stall");
    end
    for (int i = 0; i < 5; i++) begin
      pv[0] = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b1, (i > 0), 1'b0, '0, "perf_acc");
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, "perf_drain");
    checkOutput("perf_req_cnt==5", perf_req_cnt, 32'd5);
    checkOutput("perf_stall_cnt==3", perf_stall_cnt, 32'd3);
`endif

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, "rand_rst");
    for (int c = 0; c < 600; c++) begin
      bit rn, fl, aok, dok;
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && $urandom_range(0, 2) == 0) begin
          pv[p] = 1'b1;
          pr[p] = '{wr: 1'($urandom_range(0, 1)), size: mem_size_t'($urandom_range(0, 2)),
                    addr: $urandom, wdata: $urandom, wstrb: 4'($urandom_range(0, 15))};
        end
      end
      rn  = ($urandom_range(0, 63) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      aok = 1'($urandom_range(0, 1));
      dok = (rn && inflight.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      applyStimulus(rn, fl, aok, dok, 1'b0, '0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_req_sched.md
# dmem_req_sched

Data-memory request scheduler between the two execute pipes and the single MMU data port. It issues load/store requests in program order, with pipe 0 always older than pipe 1. It tracks in-flight requests in an order FIFO and routes each `mmu_data_ok`/`mmu_rdata` back to the pipe that owns it. It sits between the EX stage and the MMU; the MEM stage consumes its per-pipe responses. On pipeline flush it drops un-issued requests and silently discards responses for requests already in flight.

## Interface
- `MAX_OUTSTANDING`, default 2: maximum in-flight requests, counting discarded ones; ≥1.
- `clk`  in  1  clock
- `resetn`  in  1  synchronous reset, active low
- `flush`  in  1  pipeline flush
- `reqN_valid`  in  1  (N=0,1) request pending; held until `reqN_accept` or flush
- `reqN_wr`  in  1  store when 1, load when 0
- `reqN_size`  in  mem_size_t  access size
- `reqN_addr`  in  32  byte address
- `reqN_wdata`  in  32  store data
- `reqN_wstrb`  in  4  store byte enables
- `reqN_accept`  out  1  request taken by MMU this cycle
- `mmu_req`  out  1  request valid
- `mmu_wr`, `mmu_size`, `mmu_addr`, `mmu_wdata`, `mmu_wstrb`  out  1/mem_size_t/32/32/4  selected request fields
- `mmu_addr_ok`  in  1  request accepted
- `mmu_data_ok`  in  1  in-order response
- `mmu_rdata`  in  32  load data
- `rspN_data_ok`  out  1  response for pipe N
- `rsp_rdata`  out  32  equals `mmu_rdata`
- `busy`  out  1  any request in flight

## Operation
- Select: pipe 0 when `req0_valid`; otherwise pipe 1. Pipe 1 is never issued while `req0_valid` is high, which preserves order.
- In-flight count `N = discard_cnt + fifo_count`, width `$clog2(MAX_OUTSTANDING+1)`.
- `mmu_req = resetn && !flush && sel_valid && N < MAX_OUTSTANDING`. A same-cycle pop does not free a slot.
- Accept: `mmu_req && mmu_addr_ok`. Assert `reqN_accept` for the selected pipe and push its id (1 bit) into the FIFO.
- Response, when `mmu_data_ok` arrives without flush:
  - If `discard_cnt > 0`: decrement `discard_cnt`; no `rsp*` asserted.
  - Otherwise: pop the FIFO head id and assert `rsp<id>_data_ok` for one cycle.
- Flush:
  - Force `mmu_req` low.
  - Clear the FIFO.
  - `discard_cnt <= N - mmu_data_ok`.
  - No `rsp*` asserted that cycle.
  - Requests issued after the flush are queued behind the discards. Responses return in order, so the first `discard_cnt` responses are dropped.
- Push and pop in the same cycle are legal. FIFO full cannot occur, because issue is gated by N.
- `mmu_data_ok` with `N == 0` is a protocol error: ignored, no response, counters unchanged. Flag it with an assertion.
- `busy = (N != 0)`.

## Timing
- Request to `mmu_req`: combinational, 0 cycles.
- Accept coincides with `mmu_addr_ok`.
- Response coincides with `mmu_data_ok`; `rsp_rdata` is combinational pass-through.
- While `mmu_req` is high without `mmu_addr_ok`, the selected request's fields stay stable until accept. The only exception is flush.
- Reset (`resetn` low at a clock edge): FIFO empty and `discard_cnt = 0` at the next cycle.
- During reset: `mmu_req`, `reqN_accept`, `rspN_data_ok` and `busy` are all 0.
- Reset mid-transaction abandons in-flight requests; the MMU is reset together with this block.
- Throughput: one issue per cycle, limited by `MAX_OUTSTANDING` and `mmu_addr_ok`.

## Configuration
- Macro: `DMEM_SCHED_PERF_EN`.
- Defined: adds outputs `perf_req_cnt` (32) and `perf_stall_cnt` (32).
  - `perf_req_cnt` increments on each accept.
  - `perf_stall_cnt` increments on each cycle with `sel_valid && !flush` and no accept.
  - Both wrap at 2^32 and reset to 0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package (`definitions.svh`):
  - `mem_size_t` (already present).
  - New `dmem_req_t` struct {wr, size, addr, wdata, wstrb} used for the muxed request.
  - New constant `DMEM_PIPE_ID_W = 1`.
- Sub-module `dmem_id_fifo`: synchronous FIFO of depth `MAX_OUTSTANDING` with push/pop/clear, count and head outputs, supporting simultaneous push+pop. The scheduler instantiates it once.

## Test plan
- Single load on pipe 0, addr 0x1000; `addr_ok` in cycle 1, `data_ok` in cycle 3 with rdata 0xDEADBEEF → `req0_accept` in cycle 1, `rsp0_data_ok` in cycle 3, `rsp_rdata` 0xDEADBEEF, `busy` 0 in cycle 4.
- Both pipes valid, `addr_ok` always high → pipe 0 issued in cycle 0, pipe 1 in cycle 1; two `data_ok`s return `rsp0` then `rsp1`.
- `MAX_OUTSTANDING=2`, three back-to-back requests, `data_ok` withheld → the third has `mmu_req` low until the first `data_ok`; `mmu_req` goes high the following cycle.
- Two in flight, flush asserted alongside one `data_ok` → no `rsp` that cycle, `discard_cnt = 1`. A new pipe-0 request then issues; of the next two `data_ok`s, only the second raises `rsp0_data_ok`.
- `resetn` low while pipe 1 has a request in flight → all outputs 0. After release, a new request issues and its first `data_ok` routes correctly.
- With `DMEM_SCHED_PERF_EN`: 5 accepts and 3 `addr_ok`-low cycles → `perf_req_cnt = 5`, `perf_stall_cnt = 3`.
